// File: rtl/ula_multibyte.sv
// Byte-serial multi-precision sequencer driving one 8-bit ALU, chaining carry between bytes.
// Optional ULA_MULTIBYTE_ZERO_EN adds a done_zero flag reporting an all-zero result.
`timescale 1ns/1ps
module ula_multibyte #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_seletor,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_carry_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_A,
    input  logic [7:0]       in_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_resultado,
    output logic             out_last,
    output logic             done_valid,
    output logic             done_carry_out,
`ifdef ULA_MULTIBYTE_ZERO_EN
    output logic             done_zero,
`endif
    output logic             busy,
    output logic [7:0]       ula_A,
    output logic [7:0]       ula_B,
    output logic             ula_carry_in,
    output logic [2:0]       ula_seletor,
    input  logic [7:0]       ula_resultado,
    input  logic             ula_carry_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] count;
    logic             carry_reg;
    logic [2:0]       seletor_reg;
    logic             cmd_hs;
    logic             in_hs;
    logic             out_hs;
`ifdef ULA_MULTIBYTE_ZERO_EN
    logic             zero_flag;
`endif

    assign cmd_hs       = cmd_valid && cmd_ready;
    assign in_hs        = in_valid && in_ready;
    assign out_hs       = out_valid && out_ready;
    assign busy         = (state != IDLE);
    assign ula_A        = in_A;
    assign ula_B        = in_B;
    assign ula_carry_in = carry_reg;
    assign ula_seletor  = seletor_reg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) state_next = RUN;
            end
            RUN: begin
                // A new byte may enter only if the output register is free or being emptied
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && (count == remaining)) state_next = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining      <= '0;
            count          <= '0;
            carry_reg      <= 1'b0;
            seletor_reg    <= 3'd0;
            out_valid      <= 1'b0;
            out_resultado  <= 8'd0;
            out_last       <= 1'b0;
            done_valid     <= 1'b0;
            done_carry_out <= 1'b0;
`ifdef ULA_MULTIBYTE_ZERO_EN
            zero_flag      <= 1'b0;
            done_zero      <= 1'b0;
`endif
        end else begin
            done_valid <= 1'b0;
`ifdef ULA_MULTIBYTE_ZERO_EN
            done_zero  <= 1'b0;
`endif
            if (cmd_hs) begin
                seletor_reg <= cmd_seletor;
                carry_reg   <= cmd_carry_in;
                remaining   <= cmd_len;
                count       <= '0;
`ifdef ULA_MULTIBYTE_ZERO_EN
                zero_flag   <= 1'b1;
`endif
            end
            if (in_hs) begin
                out_resultado <= ula_resultado;
                out_valid     <= 1'b1;
                carry_reg     <= ula_carry_out;
                out_last      <= (count == remaining);
                count         <= count + 1'b1;
`ifdef ULA_MULTIBYTE_ZERO_EN
                if (ula_resultado != 8'd0) zero_flag <= 1'b0;
`endif
            end else if (out_hs) begin
                out_valid <= 1'b0;
                if (out_last) begin
                    out_last       <= 1'b0;
                    done_valid     <= 1'b1;
                    done_carry_out <= carry_reg;
`ifdef ULA_MULTIBYTE_ZERO_EN
                    done_zero      <= zero_flag;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_multibyte.sv
// Self-checking bench for ula_multibyte: closes the loop with an adder ALU and compares
// every result byte and completion against a wide-integer addition model.
`timescale 1ns/1ps
module tb_ula_multibyte;

    localparam int LEN_W = 4;
    localparam int MAXB  = 1 << LEN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_seletor = 3'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_carry_in = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_A = 8'd0;
    logic [7:0]       in_B = 8'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_resultado;
    logic             out_last;
    logic             done_valid;
    logic             done_carry_out;
`ifdef ULA_MULTIBYTE_ZERO_EN
    logic             done_zero;
`endif
    logic             busy;
    logic [7:0]       ula_A;
    logic [7:0]       ula_B;
    logic             ula_carry_in;
    logic [2:0]       ula_seletor;
    logic [7:0]       ula_resultado;
    logic             ula_carry_out;
    logic [8:0]       alu_sum;

    ula_multibyte #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seletor(cmd_seletor),
        .cmd_len(cmd_len), .cmd_carry_in(cmd_carry_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
        .out_valid(out_valid), .out_ready(out_ready), .out_resultado(out_resultado),
        .out_last(out_last), .done_valid(done_valid), .done_carry_out(done_carry_out),
`ifdef ULA_MULTIBYTE_ZERO_EN
        .done_zero(done_zero),
`endif
        .busy(busy), .ula_A(ula_A), .ula_B(ula_B), .ula_carry_in(ula_carry_in),
        .ula_seletor(ula_seletor), .ula_resultado(ula_resultado), .ula_carry_out(ula_carry_out)
    );

    always #5 clk = ~clk;

    // Adder ALU closing the loop
    assign alu_sum       = {1'b0, ula_A} + {1'b0, ula_B} + {8'd0, ula_carry_in};
    assign ula_resultado = alu_sum[7:0];
    assign ula_carry_out = alu_sum[8];

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];
    logic [1:0] done_q[$];
    logic [7:0] obs_q[$];
    logic       obs_carry = 1'b0;
    logic       obs_zero  = 1'b0;
    int         done_cnt  = 0;
    bit         bp_auto     = 1'b0;
    logic       force_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] obs_at(input int i);
        if (i < obs_q.size()) return 32'(obs_q[i]);
        return 32'hxxxxxxxx;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = bp_auto ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    logic       in_hs_prev   = 1'b0;
    logic       last_hs_prev = 1'b0;
    logic       stall_prev   = 1'b0;
    logic [7:0] stall_val    = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            in_hs_prev   = 1'b0;
            last_hs_prev = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            if (in_hs_prev) check("latency", 32'(out_valid), 32'd1);
            if (done_valid || last_hs_prev) check("done_timing", 32'(done_valid), 32'(last_hs_prev));
            if (stall_prev) check("stall_stable", 32'(out_resultado), 32'(stall_val));
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_byte", 32'(out_resultado), 32'(e[7:0]));
                    check("out_last", 32'(out_last), 32'(e[8]));
                end
                obs_q.push_back(out_resultado);
            end
            if (done_valid) begin
                check("done_cmd_ready", 32'(cmd_ready), 32'd1);
                check("done_idle", 32'({busy, in_ready}), 32'd0);
                if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    logic [1:0] d;
                    d = done_q.pop_front();
                    check("done_carry", 32'(done_carry_out), 32'(d[0]));
`ifdef ULA_MULTIBYTE_ZERO_EN
                    check("done_zero", 32'(done_zero), 32'(d[1]));
                    obs_zero = done_zero;
`endif
                end
                obs_carry = done_carry_out;
                done_cnt++;
            end
            in_hs_prev   = in_valid && in_ready;
            last_hs_prev = out_valid && out_ready && out_last;
            stall_prev   = out_valid && !out_ready;
            stall_val    = out_resultado;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: the whole operand is one wide integer sum
    task automatic push_model(input int len, input logic cin, input logic [127:0] a, input logic [127:0] b);
        int          n;
        logic [127:0] am, bm;
        logic [128:0] sum;
        logic         zero;
        n  = len + 1;
        am = '0;
        bm = '0;
        for (int i = 0; i < n; i++) begin
            am[8*i +: 8] = a[8*i +: 8];
            bm[8*i +: 8] = b[8*i +: 8];
        end
        sum  = {1'b0, am} + {1'b0, bm} + 129'(cin);
        zero = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == len), sum[8*i +: 8]});
            if (sum[8*i +: 8] != 8'd0) zero = 1'b0;
        end
        done_q.push_back({zero, sum[8*n]});
    endtask

    task automatic send_cmd(input logic [2:0] sel, input int len, input logic cin);
        int t;
        cmd_valid    = 1'b1;
        cmd_seletor  = sel;
        cmd_len      = LEN_W'(len);
        cmd_carry_in = cin;
        t = 0;
        while (!cmd_ready && t < 300) begin tick(); t++; end
        if (t >= 300) check("cmd_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid    = 1'b0;
        cmd_seletor  = 3'($urandom);
        cmd_carry_in = 1'($urandom);
        check("seletor_latched", 32'(ula_seletor), 32'(sel));
        check("carry_latched", 32'(ula_carry_in), 32'(cin));
    endtask

    task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 2) == 0) tick();
        in_valid = 1'b1;
        in_A     = a;
        in_B     = b;
        t = 0;
        while (!in_ready && t < 300) begin tick(); t++; end
        if (t >= 300) check("in_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_A     = 8'($urandom);
        in_B     = 8'($urandom);
    endtask

    task automatic run_txn(input logic [2:0] sel, input int len, input logic cin,
                           input logic [127:0] a, input logic [127:0] b, input bit gaps);
        int start;
        int t;
        push_model(len, cin, a, b);
        obs_q.delete();
        start = done_cnt;
        send_cmd(sel, len, cin);
        for (int i = 0; i <= len; i++) send_byte(a[8*i +: 8], b[8*i +: 8], gaps);
        t = 0;
        while (done_cnt == start && t < 300) begin tick(); t++; end
        if (t >= 300) check("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ra, rb;
        int           len;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out", 32'({out_valid, out_last, out_resultado}), 32'd0);
        check("rst_done", 32'({done_valid, done_carry_out}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ula", 32'({ula_carry_in, ula_seletor}), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // 0x00FF + 0x0001 = 0x0100
        run_txn(3'd0, 1, 1'b0, 128'h00FF, 128'h0001, 1'b0);
        check("t1_count", 32'(obs_q.size()), 32'd2);
        check("t1_b0", obs_at(0), 32'h00);
        check("t1_b1", obs_at(1), 32'h01);
        check("t1_carry", 32'(obs_carry), 32'd0);

        // 0xFFFF + 0x0001 = 0x1_0000
        run_txn(3'd2, 1, 1'b0, 128'hFFFF, 128'h0001, 1'b0);
        check("t2_b0", obs_at(0), 32'h00);
        check("t2_b1", obs_at(1), 32'h00);
        check("t2_carry", 32'(obs_carry), 32'd1);

        // single byte with carry-in: 0x7F + 0x00 + 1 = 0x80
        run_txn(3'd1, 0, 1'b1, 128'h7F, 128'h00, 1'b0);
        check("t3_count", 32'(obs_q.size()), 32'd1);
        check("t3_b0", obs_at(0), 32'h80);
        check("t3_carry", 32'(obs_carry), 32'd0);

        // output stall for 3 cycles after the first result
        force_ready = 1'b0;
        fork
            run_txn(3'd4, 3, 1'b0, 128'h12345678, 128'h11111111, 1'b0);
            begin
                int t;
                t = 0;
                while (!out_valid && t < 100) begin tick(); t++; end
                for (int k = 0; k < 3; k++) begin
                    check("t4_hold_in_ready", 32'(in_ready), 32'd0);
                    check("t4_hold_data", 32'(out_resultado), 32'h89);
                    tick();
                end
                force_ready = 1'b1;
            end
        join
        check("t4_count", 32'(obs_q.size()), 32'd4);
        check("t4_b0", obs_at(0), 32'h89);
        check("t4_b1", obs_at(1), 32'h67);
        check("t4_b2", obs_at(2), 32'h45);
        check("t4_b3", obs_at(3), 32'h23);

        // maximum length, carry ripples through all bytes
        run_txn(3'd5, MAXB - 1, 1'b0, {128{1'b1}}, 128'h1, 1'b0);
        check("tmax_count", 32'(obs_q.size()), 32'(MAXB));
        check("tmax_b15", obs_at(MAXB - 1), 32'h00);
        check("tmax_carry", 32'(obs_carry), 32'd1);

        // abort mid-transaction with carry_reg=1
        push_model(3, 1'b0, 128'h0000FFFF, 128'h00000001);
        send_cmd(3'd6, 3, 1'b0);
        send_byte(8'hFF, 8'h01, 1'b0);
        send_byte(8'hFF, 8'h00, 1'b0);
        check("abort_pre_carry", 32'(ula_carry_in), 32'd1);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_carry", 32'(ula_carry_in), 32'd0);
        check("abort_regs", 32'({out_last, done_valid, ula_seletor}), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check("abort_idle", 32'(cmd_ready), 32'd1);
        run_txn(3'd0, 0, 1'b0, 128'h01, 128'h01, 1'b0);
        check("abort_new_b0", obs_at(0), 32'h02);

`ifdef ULA_MULTIBYTE_ZERO_EN
        run_txn(3'd0, 1, 1'b0, 128'h0000, 128'h0000, 1'b0);
        check("zero_all", 32'(obs_zero), 32'd1);
        run_txn(3'd0, 1, 1'b0, 128'h00FF, 128'h0001, 1'b0);
        check("zero_some", 32'(obs_zero), 32'd0);
`endif

        // randomized transactions with backpressure and input gaps
        bp_auto = 1'b1;
        for (int n = 0; n < 40; n++) begin
            len = (n % 8 == 0) ? MAXB - 1 : $urandom_range(0, MAXB - 1);
            for (int i = 0; i < MAXB; i++) begin
                ra[8*i +: 8] = rand_byte();
                rb[8*i +: 8] = rand_byte();
            end
            run_txn(3'($urandom), len, 1'($urandom), ra, rb, 1'b1);
        end
        bp_auto = 1'b0;
        repeat (3) tick();
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("done_drained", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
